// File: rtl/rr_onehot_arbiter_pkg.sv
// rr_onehot_arbiter_pkg: shared widths and FSM state encoding for the round-robin arbiter and its encoder
package rr_onehot_arbiter_pkg;
  localparam int NUM_REQ = 16;
  localparam int IDX_W = 4;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// rr_pick16: combinational round-robin find (pending, ptr -> onehot, idx, any) via rotate/priority-find/rotate-back
module rr_pick16
  import rr_onehot_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  logic [2*NUM_REQ-1:0] dbl, back;
  logic [NUM_REQ-1:0] rot, low;
  logic [IDX_W-1:0] ridx;
  always_comb begin
    dbl = {pending, pending} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    low = rot & (~rot + 1'b1);
    back = {low, low} << ptr;
    onehot = back[2*NUM_REQ-1:NUM_REQ];
    ridx = '0;
    for (int i = 0; i < NUM_REQ; i++) ridx = low[i] ? IDX_W'(i) : ridx;
    idx = ridx + ptr;
    any = |pending;
  end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: 16-line event capture with round-robin one-hot grant (ports: clk, reset, req_in, grant_ack -> grant_16, grant_valid, pending, overflow)
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               grant_ack,
  output logic [NUM_REQ-1:0] grant_16,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] overflow
);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] req_q, rise, clr, pick_onehot, grant_d;
  logic [IDX_W-1:0] ptr, ptr_d, gidx, gidx_d, pick_idx;
  logic pick_any, valid_d, ack;
  assign rise = EDGE_DETECT ? req_in & ~req_q : req_in;
  assign ack = (state_q == ST_GRANT) & grant_ack;
  assign clr = ack ? grant_16 : '0;
  rr_pick16 u_pick (
    .pending(pending),
    .ptr(ptr),
    .onehot(pick_onehot),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_16;
    valid_d = grant_valid;
    gidx_d = gidx;
    ptr_d = ptr;
    if (state_q == ST_IDLE && pick_any) begin
      state_d = ST_GRANT;
      grant_d = pick_onehot;
      valid_d = 1'b1;
      gidx_d = pick_idx;
    end else if (ack) begin
      state_d = ST_IDLE;
      grant_d = '0;
      valid_d = 1'b0;
      ptr_d = gidx + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_16 <= '0;
      grant_valid <= 1'b0;
      gidx <= '0;
      ptr <= '0;
      req_q <= '0;
      pending <= '0;
      overflow <= '0;
    end else begin
      state_q <= state_d;
      grant_16 <= grant_d;
      grant_valid <= valid_d;
      gidx <= gidx_d;
      ptr <= ptr_d;
      req_q <= req_in;
      pending <= (pending & ~clr) | rise;
      overflow <= overflow | (EDGE_DETECT ? rise & pending & ~clr : '0);
    end
  end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: scoreboard bench for rr_onehot_arbiter
module tb_rr_onehot_arbiter;
  logic clk = 1'b0, reset = 1'b1, grant_ack = 1'b0;
  logic [15:0] req_in = '0;
  logic [15:0] grant_16, pending, overflow;
  logic grant_valid;
  logic [15:0] sb[$];
  logic [15:0] exp_g;
  int checks = 0, failures = 0;
  bit ok;
  int n;
  always #5 clk = ~clk;
  rr_onehot_arbiter #(.EDGE_DETECT(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .req_in(req_in),
    .grant_ack(grant_ack),
    .grant_16(grant_16),
    .grant_valid(grant_valid),
    .pending(pending),
    .overflow(overflow)
  );
  function automatic int enc(input logic [15:0] g);
    int r = 0;
    for (int i = 0; i < 16; i++) r = g[i] ? i : r;
    return r;
  endfunction
  task automatic wait_valid(output bit got, output int cnt);
    got = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (grant_valid) begin
        got = 1;
        break;
      end
    end
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    req_in = '0;
    grant_ack = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant_16, grant_valid, pending, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_hold got g=%h v=%b p=%h o=%h want all 0", grant_16, grant_valid, pending, overflow);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if ({grant_16, grant_valid, pending, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_release got g=%h v=%b p=%h o=%h want all 0", grant_16, grant_valid, pending, overflow);
    end
  endtask
  task automatic test_single();
    apply_reset();
    req_in = 16'h0020;
    sb.push_back(16'h0020);
    @(negedge clk);
    req_in = '0;
    checks++;
    if (pending !== 16'h0020 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_t1 got p=%h v=%b want p=0020 v=0", pending, grant_valid);
    end
    @(negedge clk);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (grant_valid !== 1'b1 || grant_16 !== exp_g || enc(grant_16) != 5) begin
      failures++;
      $display("FAIL single_t2 got v=%b g=%h code=%0d want v=1 g=%h code=5", grant_valid, grant_16, enc(grant_16), exp_g);
    end
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || grant_16 !== '0 || pending !== '0) begin
      failures++;
      $display("FAIL single_ack got v=%b g=%h p=%h want 0 0 0", grant_valid, grant_16, pending);
    end
    req_in = 16'h00A0;
    sb.push_back(16'h0080);
    sb.push_back(16'h0020);
    @(negedge clk);
    req_in = '0;
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok, n);
      exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
      checks++;
      if (!ok || grant_16 !== exp_g) begin
        failures++;
        $display("FAIL single_ptr6[%0d] got g=%h valid=%b want %h", k, grant_16, ok, exp_g);
      end
      grant_ack = 1'b1;
      @(negedge clk);
      grant_ack = 1'b0;
    end
  endtask
  task automatic test_wrap();
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      req_in = pass ? 16'h8002 : 16'h8001;
      sb.push_back(pass ? 16'h0002 : 16'h0001);
      sb.push_back(16'h8000);
      @(negedge clk);
      req_in = '0;
      for (int k = 0; k < 2; k++) begin
        wait_valid(ok, n);
        exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (!ok || grant_16 !== exp_g) begin
          failures++;
          $display("FAIL wrap[%0d.%0d] got g=%h valid=%b want %h", pass, k, grant_16, ok, exp_g);
        end
        grant_ack = 1'b1;
        @(negedge clk);
        grant_ack = 1'b0;
      end
    end
  endtask
  task automatic test_all_pending();
    apply_reset();
    req_in = 16'h0004;
    sb.push_back(16'h0004);
    @(negedge clk);
    req_in = '0;
    wait_valid(ok, n);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || grant_16 !== exp_g) begin
      failures++;
      $display("FAIL all_setup got g=%h want %h", grant_16, exp_g);
    end
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    req_in = 16'hFFFF;
    for (int k = 0; k < 16; k++) sb.push_back(16'h0001 << ((3 + k) % 16));
    @(negedge clk);
    req_in = '0;
    for (int k = 0; k < 16; k++) begin
      wait_valid(ok, n);
      exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
      checks++;
      if (!ok || grant_16 !== exp_g || n != 1) begin
        failures++;
        $display("FAIL all_rot[%0d] got g=%h gap=%0d want g=%h gap=1", k, grant_16, n, exp_g);
      end
      grant_ack = 1'b1;
      @(negedge clk);
      grant_ack = 1'b0;
    end
    checks++;
    if (pending !== '0 || grant_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL all_end got p=%h v=%b left=%0d want p=0 v=0 left=0", pending, grant_valid, sb.size());
    end
  endtask
  task automatic test_overflow();
    apply_reset();
    req_in = 16'h0080;
    sb.push_back(16'h0080);
    @(negedge clk);
    req_in = '0;
    wait_valid(ok, n);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || grant_16 !== exp_g || overflow !== '0) begin
      failures++;
      $display("FAIL ovf_grant got g=%h o=%h want g=%h o=0", grant_16, overflow, exp_g);
    end
    req_in = 16'h0080;
    @(negedge clk);
    req_in = '0;
    checks++;
    if (overflow !== 16'h0080 || grant_16 !== 16'h0080 || grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got o=%h g=%h v=%b want o=0080 g=0080 v=1", overflow, grant_16, grant_valid);
    end
    @(negedge clk);
    req_in = 16'h0080;
    grant_ack = 1'b1;
    sb.push_back(16'h0080);
    @(negedge clk);
    req_in = '0;
    grant_ack = 1'b0;
    checks++;
    if (pending !== 16'h0080 || overflow !== 16'h0080 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ackrise got p=%h o=%h v=%b want p=0080 o=0080 v=0", pending, overflow, grant_valid);
    end
    wait_valid(ok, n);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || grant_16 !== exp_g) begin
      failures++;
      $display("FAIL ovf_regrant got g=%h want %h", grant_16, exp_g);
    end
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    checks++;
    if (pending !== '0 || overflow !== 16'h0080) begin
      failures++;
      $display("FAIL ovf_sticky got p=%h o=%h want p=0 o=0080", pending, overflow);
    end
  endtask
  task automatic test_hold();
    apply_reset();
    grant_ack = 1'b1;
    repeat (3) @(negedge clk);
    grant_ack = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || pending !== '0 || overflow !== '0) begin
      failures++;
      $display("FAIL idle_ack got v=%b p=%h o=%h want 0 0 0", grant_valid, pending, overflow);
    end
    req_in = 16'h0011;
    sb.push_back(16'h0001);
    @(negedge clk);
    req_in = '0;
    wait_valid(ok, n);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || grant_16 !== exp_g) begin
      failures++;
      $display("FAIL idle_ack_ptr got g=%h want %h", grant_16, exp_g);
    end
    for (int k = 0; k < 10; k++) begin
      req_in = 16'($urandom) & 16'hFFFE;
      @(negedge clk);
      checks++;
      if (grant_16 !== 16'h0001 || grant_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d] got g=%h v=%b want g=0001 v=1", k, grant_16, grant_valid);
      end
    end
    req_in = '0;
  endtask
  task automatic test_reset_mid();
    apply_reset();
    req_in = 16'h00F0;
    sb.push_back(16'h0010);
    @(negedge clk);
    req_in = '0;
    wait_valid(ok, n);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || grant_16 !== exp_g || pending !== 16'h00F0) begin
      failures++;
      $display("FAIL mid_grant got g=%h p=%h want g=%h p=00f0", grant_16, pending, exp_g);
    end
    req_in = 16'h0200;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({grant_16, grant_valid, pending, overflow} !== '0) begin
      failures++;
      $display("FAIL mid_async got g=%h v=%b p=%h o=%h want all 0", grant_16, grant_valid, pending, overflow);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(16'h0200);
    wait_valid(ok, n);
    exp_g = sb.size() ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (!ok || grant_16 !== exp_g) begin
      failures++;
      $display("FAIL mid_held_event got g=%h want %h", grant_16, exp_g);
    end
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || pending !== '0 || overflow !== '0) begin
      failures++;
      $display("FAIL mid_one_event got v=%b p=%h o=%h want 0 0 0", grant_valid, pending, overflow);
    end
    req_in = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_all_pending();
    test_overflow();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
